led7scan: RTL
=============

// Module: led7scan
// PURPOSE
//  Time-multiplexed scanner for a common-anode multi-digit 7-segment display.
//  Holds one hex nibble per digit and cycles through the digits.
//  Each scan slot drives one active-low anode and presents that digit's nibble on o_w_digit.
//  o_w_digit feeds the per-digit hex-to-segment converter downstream, which produces the segment lines.
//  New values are double-buffered and applied only at frame boundaries, so a frame never tears.
// PARAMETERS
//  DIGITS        4     number of digits scanned; legal range 1..8
//  REFRESH_DIV   8192  clock cycles per digit slot; must be >= 2
//  BLANK_CYCLES  64    cycles at the start of each slot with all anodes off (anti-ghosting); must be < REFRESH_DIV
// PORTS
//  i_w_clk          in   1          clock
//  i_w_rst_n        in   1          synchronous reset, active low
//  i_w_load         in   1          1-cycle strobe: capture value/dp/enable into the pending buffer
//  i_w_value        in   4*DIGITS   nibble k = value[4k+3:4k] belongs to digit k
//  i_w_dp_mask      in   DIGITS     bit k=1: decimal point of digit k lit
//  i_w_en_mask      in   DIGITS     bit k=1: digit k enabled; disabled digits keep their anode off for the whole slot
//  o_w_an           out  DIGITS     anodes, active low, at most one low at any time
//  o_w_digit        out  4          nibble of the current digit, to the segment converter
//  o_w_dp_n         out  1          decimal point, active low
//  o_w_frame_tick   out  1          1-cycle pulse on the last cycle of the frame
//  o_w_busy         out  1          pending buffer holds data not yet displayed
// BEHAVIOUR
//  State registers:
//   - slot counter cnt, width $clog2(REFRESH_DIV)
//   - digit index idx, width $clog2(DIGITS) with minimum 1
//   - display registers disp_val, disp_dp, disp_en
//   - pending registers pend_val, pend_dp, pend_en, plus flag pend
//  Reset (i_w_rst_n=0 sampled at the clock edge) clears everything:
//   - cnt=0, idx=0, all disp_* and pend_* registers = 0, pend = 0
//   - outputs: o_w_an = all 1, o_w_digit = 0, o_w_dp_n = 1, o_w_frame_tick = 0, o_w_busy = 0
//   - reset mid-frame aborts the frame at once; no partial slot is completed
//  Counting:
//   - cnt increments every cycle; at REFRESH_DIV-1 it wraps to 0 and idx advances
//   - idx wraps from DIGITS-1 to 0
//  Frame boundary: the cycle with idx = DIGITS-1 and cnt = REFRESH_DIV-1.
//   - o_w_frame_tick = 1 in that cycle only
//   - if pend = 1: disp_* <= pend_*, pend <= 0 at that edge
//  Load:
//   - i_w_load = 1: pend_* <= inputs, pend <= 1
//   - load on the frame-boundary cycle: disp_* <= inputs directly, pend stays 0 (bypass)
//   - repeated loads before a boundary: last one wins
//   - i_w_load while in reset is ignored
//  Outputs are decoded from registered state, with no extra latency:
//   - cnt < BLANK_CYCLES: o_w_an = all 1
//   - otherwise: o_w_an[idx] = ~disp_en[idx], all other bits 1
//   - o_w_digit = disp_val[4*idx +: 4], valid for the whole slot including the blank window
//   - o_w_dp_n = ~(disp_dp[idx] & disp_en[idx] & (cnt >= BLANK_CYCLES))
//   - o_w_busy = pend
//  DIGITS = 1: idx is constant 0 and every slot end is a frame boundary.
// TESTING (DIGITS=4, REFRESH_DIV=8, BLANK_CYCLES=2; frame = 32 cycles)
//  1 Hold rst_n=0 for 3 cycles
//    -> o_w_an=4'b1111, o_w_digit=0, o_w_dp_n=1, o_w_frame_tick=0, o_w_busy=0.
//  2 After reset, load value=16'hA3F1, en=4'b1111, dp=4'b0100 at cnt=1
//    -> busy=1 until the tick at the 32nd cycle after reset
//    -> next frame, per slot cnt 2..7:
//       an=1110 digit=1; an=1101 digit=F; an=1011 digit=3 dp_n=0; an=0111 digit=A
//    -> an=1111 at cnt 0..1 of every slot.
//  3 en=4'b0101 loaded and applied
//    -> slots 1 and 3 keep an=1111 and dp_n=1 for all 8 cycles
//    -> slots 0 and 2 scan normally.
//  4 Load 16'h0042 exactly on the frame-boundary cycle
//    -> busy never asserts; slot 0 of the next frame shows digit=2.
//  5 Assert reset at idx=2, cnt=5
//    -> next cycle cnt=0, idx=0, an=1111, display cleared
//    -> first tick comes 32 cycles after reset is released.
//  6 Load 16'h1111 then 16'h2222 within one frame
//    -> the next frame shows 2 on all digits; 1 never appears.

Source files
------------

// File: rtl/led7scan.sv
// led7scan: time-multiplexed scanner for a common-anode multi-digit 7-segment display.
//
// Holds one hex nibble per digit and walks through the digits one slot at a time.
// Each slot starts with a blank window in which every anode is off, to suppress ghosting.
// New values go into a pending buffer first.
// The pending buffer reaches the display registers only at a frame boundary, so a frame never tears.
//
// Ports
//   i_w_clk         clock
//   i_w_rst_n       synchronous reset, active low
//   i_w_load        1-cycle strobe: capture value/dp/enable into the pending buffer
//   i_w_value       nibble k = value[4k+3:4k] belongs to digit k
//   i_w_dp_mask     bit k=1: decimal point of digit k lit
//   i_w_en_mask     bit k=1: digit k enabled
//   o_w_an          anodes, active low, at most one low at any time
//   o_w_digit       nibble of the current digit, for the downstream segment converter
//   o_w_dp_n        decimal point, active low
//   o_w_frame_tick  1-cycle pulse on the last cycle of each frame
//   o_w_busy        pending buffer holds data not yet displayed
module led7scan #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 8192,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                  i_w_clk,
  input  logic                  i_w_rst_n,
  input  logic                  i_w_load,
  input  logic [4*DIGITS-1:0]   i_w_value,
  input  logic [DIGITS-1:0]     i_w_dp_mask,
  input  logic [DIGITS-1:0]     i_w_en_mask,
  output logic [DIGITS-1:0]     o_w_an,
  output logic [3:0]            o_w_digit,
  output logic                  o_w_dp_n,
  output logic                  o_w_frame_tick,
  output logic                  o_w_busy
);

  localparam int CNT_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_BLANK = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] disp_val_q, disp_val_d;
  logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
  logic [DIGITS-1:0]   disp_en_q, disp_en_d;
  logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [DIGITS-1:0]   pend_en_q, pend_en_d;
  logic                pend_q, pend_d;

  logic slot_end;
  logic frame_end;

  always_comb begin
    slot_end   = (cnt_q == CNT_LAST);
    frame_end  = slot_end && (idx_q == IDX_LAST);

    cnt_d      = slot_end ? '0 : cnt_q + CNT_W'(1);
    idx_d      = idx_q;
    if (slot_end) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    disp_val_d = disp_val_q;
    disp_dp_d  = disp_dp_q;
    disp_en_d  = disp_en_q;
    pend_val_d = pend_val_q;
    pend_dp_d  = pend_dp_q;
    pend_en_d  = pend_en_q;
    pend_d     = pend_q;

    if (frame_end && i_w_load) begin
      // A load landing on the boundary goes straight to the display.
      // It also supersedes anything still pending.
      disp_val_d = i_w_value;
      disp_dp_d  = i_w_dp_mask;
      disp_en_d  = i_w_en_mask;
      pend_d     = 1'b0;
    end else if (frame_end && pend_q) begin
      disp_val_d = pend_val_q;
      disp_dp_d  = pend_dp_q;
      disp_en_d  = pend_en_q;
      pend_d     = 1'b0;
    end else if (i_w_load) begin
      pend_val_d = i_w_value;
      pend_dp_d  = i_w_dp_mask;
      pend_en_d  = i_w_en_mask;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge i_w_clk) begin
    if (!i_w_rst_n) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      disp_val_q <= '0;
      disp_dp_q  <= '0;
      disp_en_q  <= '0;
      pend_val_q <= '0;
      pend_dp_q  <= '0;
      pend_en_q  <= '0;
      pend_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_val_q <= disp_val_d;
      disp_dp_q  <= disp_dp_d;
      disp_en_q  <= disp_en_d;
      pend_val_q <= pend_val_d;
      pend_dp_q  <= pend_dp_d;
      pend_en_q  <= pend_en_d;
      pend_q     <= pend_d;
    end
  end

  // Output decode works directly on the registered state, so it adds no latency.
  logic blank;
  logic dp_on;

  always_comb begin
    blank     = (cnt_q < CNT_BLANK);
    o_w_an    = '1;
    o_w_digit = 4'h0;
    dp_on     = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        o_w_digit = disp_val_q[4*k +: 4];
        dp_on     = disp_dp_q[k] & disp_en_q[k];
        if (!blank) begin
          o_w_an[k] = ~disp_en_q[k];
        end
      end
    end
    o_w_dp_n       = ~(dp_on & ~blank);
    o_w_frame_tick = frame_end;
    o_w_busy       = pend_q;
  end

endmodule
